// File: rtl/ultrasonic_ping_scheduler.sv
// ultrasonic_ping_scheduler
//   Owns one HC-SR04-style ultrasonic sensor and shares it between two
//   requesters. A round-robin arbiter picks an owner, then one ping is run:
//   trigger pulse, wait for echo rise, measure echo width, then holdoff.
//   A timeout is applied from trigger end to echo fall.
//
// Ports
//   clk_50M       system clock
//   reset         asynchronous, active-high reset
//   req[1:0]      level request per requester, held until granted
//   gnt[1:0]      one-hot owner of the ping in progress, 0 when idle
//   UV_trig       sensor trigger output
//   UV_echo       sensor echo input (asynchronous, synchronised here)
//   busy          high whenever the sequencer is not idle
//   result_valid  one-cycle pulse when a result is ready
//   result_owner  requester index of the result
//   timeout       result came from a timeout
//   echo_us       echo high time in microseconds
//   dist_mm       distance in millimetres, (echo_us * 1412) >> 13
//   fault_near    distance below NEAR_MM (only with UV_FAULT_NEAR_EN)
//   dbg_state     current sequencer state
//
// Handshake: a requester raises req and holds it until its gnt bit rises;
// dropping it afterwards does not abort the ping. result_valid is a single
// cycle pulse with no back-pressure; result fields hold until the next one.
//
// Optional feature: define UV_FAULT_NEAR_EN to build the registered
// near-distance comparator behind fault_near; otherwise it is tied to 0.
module ultrasonic_ping_scheduler #(
  parameter int CLK_DIV_US = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int HOLDOFF_US = 60000,
  parameter int NEAR_MM    = 100
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic        UV_trig,
  input  logic        UV_echo,
  output logic        busy,
  output logic        result_valid,
  output logic        result_owner,
  output logic        timeout,
  output logic [15:0] echo_us,
  output logic [13:0] dist_mm,
  output logic        fault_near,
  output logic [2:0]  dbg_state
);

  localparam int TRIG_CYC = TRIG_US * CLK_DIV_US;
  localparam int MAX_A    = (TRIG_CYC > TIMEOUT_US) ? TRIG_CYC : TIMEOUT_US;
  localparam int CNT_MAX  = (MAX_A > HOLDOFF_US) ? MAX_A : HOLDOFF_US;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int PRE_W    = (CLK_DIV_US > 1) ? $clog2(CLK_DIV_US) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               echo_s1_q, echo_s2_q;
  logic               seen_low_q, seen_low_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        meas_q, meas_d;
  logic               uv_trig_q, uv_trig_d;
  logic               rv_q, rv_d;
  logic               owner_q, owner_d;
  logic               to_q, to_d;
  logic [15:0]        echo_us_q, echo_us_d;
  logic [13:0]        dist_q, dist_d;
  logic               tick;
  logic               win;
  logic               res_now, res_to;
  logic [13:0]        dist_new;

  assign tick = (pre_q == PRE_W'(CLK_DIV_US - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    seen_low_d = seen_low_q;
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d      = cnt_q;
    meas_d     = meas_q;
    uv_trig_d  = 1'b0;
    rv_d       = 1'b0;
    owner_d    = owner_q;
    to_d       = to_q;
    echo_us_d  = echo_us_q;
    dist_d     = dist_q;
    win        = ptr_q;
    res_now    = 1'b0;
    res_to     = 1'b0;
    dist_new   = 14'((27'(meas_q) * 27'd1412) >> 13);

    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        cnt_d = '0;
        if (req != 2'b00) begin
          // Pointer requester wins ties; pointer then moves past the winner.
          win     = req[ptr_q] ? ptr_q : ~ptr_q;
          gnt_d   = win ? 2'b10 : 2'b01;
          ptr_d   = ~win;
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYC)) begin
          state_d    = S_WAIT_RISE;
          cnt_d      = '0;
          pre_d      = '0;
          seen_low_d = 1'b0;
        end else begin
          uv_trig_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_RISE: begin
        if (tick) cnt_d = cnt_q + CNT_W'(1);
        if (!echo_s2_q) seen_low_d = 1'b1;
        if (cnt_q == CNT_W'(TIMEOUT_US)) begin
          res_now = 1'b1;
          res_to  = 1'b1;
        end else if (seen_low_q && echo_s2_q) begin
          // A stale-high echo is ignored until it has been seen low.
          // The rise cycle is prescaler phase 0, so an N us pulse gives N ticks.
          state_d = S_MEASURE;
          meas_d  = '0;
          pre_d   = PRE_W'((CLK_DIV_US > 1) ? 1 : 0);
        end
      end
      S_MEASURE: begin
        if (!echo_s2_q) begin
          res_now = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_US)) begin
          res_now = 1'b1;
          res_to  = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (meas_q != 16'hFFFF) meas_d = meas_q + 16'd1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_US)) state_d = S_IDLE;
        else if (tick) cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (res_now) begin
      rv_d      = 1'b1;
      to_d      = res_to;
      owner_d   = gnt_q[1];
      echo_us_d = res_to ? 16'd0 : meas_q;
      dist_d    = res_to ? 14'd0 : dist_new;
      gnt_d     = 2'b00;
      state_d   = S_HOLDOFF;
      pre_d     = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      gnt_q      <= 2'b00;
      echo_s1_q  <= 1'b0;
      echo_s2_q  <= 1'b0;
      seen_low_q <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      meas_q     <= '0;
      uv_trig_q  <= 1'b0;
      rv_q       <= 1'b0;
      owner_q    <= 1'b0;
      to_q       <= 1'b0;
      echo_us_q  <= '0;
      dist_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      echo_s1_q  <= UV_echo;
      echo_s2_q  <= echo_s1_q;
      seen_low_q <= seen_low_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      meas_q     <= meas_d;
      uv_trig_q  <= uv_trig_d;
      rv_q       <= rv_d;
      owner_q    <= owner_d;
      to_q       <= to_d;
      echo_us_q  <= echo_us_d;
      dist_q     <= dist_d;
    end
  end

`ifdef UV_FAULT_NEAR_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (res_now) fault_d = !res_to && (dist_new < 14'(NEAR_MM));
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault_near = fault_q;
`else
  assign fault_near = 1'b0;
`endif

  assign gnt          = gnt_q;
  assign UV_trig      = uv_trig_q;
  assign busy         = (state_q != S_IDLE);
  assign result_valid = rv_q;
  assign result_owner = owner_q;
  assign timeout      = to_q;
  assign echo_us      = echo_us_q;
  assign dist_mm      = dist_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ultrasonic_ping_scheduler.sv
// Bench for ultrasonic_ping_scheduler with time parameters scaled down so
// every scenario fits a short run. Expected results are pushed to exp_q
// when an echo is scheduled and popped by the result monitor.
module tb_ultrasonic_ping_scheduler;
  localparam int CLK_DIV_US = 4;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 2500;
  localparam int HOLDOFF_US = 200;
  localparam int NEAR_MM    = 100;
  localparam int TRIG_CYC   = TRIG_US * CLK_DIV_US;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic        uv_echo = 1'b0;
  logic [1:0]  gnt;
  logic        UV_trig, busy, result_valid, result_owner, timeout, fault_near;
  logic [15:0] echo_us;
  logic [13:0] dist_mm;
  logic [2:0]  dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          n_results = 0;
  longint      cyc = 0;
  logic        rv_prev = 1'b0;
  logic [31:0] exp_q[$];

  ultrasonic_ping_scheduler #(
    .CLK_DIV_US(CLK_DIV_US), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
    .HOLDOFF_US(HOLDOFF_US), .NEAR_MM(NEAR_MM)
  ) dut (
    .clk_50M(clk), .reset(rst), .req(req), .gnt(gnt), .UV_trig(UV_trig),
    .UV_echo(uv_echo), .busy(busy), .result_valid(result_valid),
    .result_owner(result_owner), .timeout(timeout), .echo_us(echo_us),
    .dist_mm(dist_mm), .fault_near(fault_near), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {owner, timeout, echo_us[15:0], dist_mm[13:0]}
  function automatic logic [31:0] exp_word(input logic owner, input logic to, input logic [15:0] us);
    logic [26:0] p;
    logic [15:0] e;
    logic [13:0] d;
    p = 27'(us) * 27'd1412;
    e = to ? 16'd0 : us;
    d = to ? 14'd0 : p[26:13];
    return {owner, to, e, d};
  endfunction

  function automatic logic fn_exp(input logic [31:0] w);
`ifdef UV_FAULT_NEAR_EN
    return !w[30] && (w[13:0] < 14'(NEAR_MM));
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && result_valid) begin
      check("rv_one_cycle", 32'(rv_prev), 32'd0);
      check("gnt_drop", 32'(gnt), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {result_owner, timeout, echo_us, dist_mm}, e);
        check("fault_near", 32'(fault_near), 32'(fn_exp(e)));
      end
      n_results++;
    end
    rv_prev <= result_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_trig(input logic level, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (UV_trig !== level && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(UV_trig), 32'(level));
  endtask

  task automatic wait_us(input int us);
    repeat (us * CLK_DIV_US) @(posedge clk);
  endtask

  // Echo pulse of width_us, then count clock edges from echo fall to result.
  task automatic echo_pulse(input int width_us, output int lat);
    @(posedge clk);
    #1 uv_echo = 1'b1;
    repeat (width_us * CLK_DIV_US) @(posedge clk);
    #1 uv_echo = 1'b0;
    lat = 0;
    while (result_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'd0, busy, exp_q.size() != 0}, 32'd0);
  endtask

  task automatic request_and_trig(input logic [1:0] r, output int lat);
    @(posedge clk);
    #1 req = r;
    lat = 0;
    while (UV_trig !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int     lat;
    int     w;
    int     n;
    int     nres;
    longint t_rise[3];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_trig", 32'(UV_trig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_result", {result_owner, timeout, echo_us, dist_mm}, 32'd0);
    check("rst_fault", 32'(fault_near), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single ping: requester 0, 100 us echo
    request_and_trig(2'b01, lat);
    check("trig_latency", 32'(lat), 32'd2);
    check("gnt_single", 32'(gnt), 32'b01);
    check("busy_single", 32'(busy), 32'd1);
    w = 0;
    while (UV_trig === 1'b1 && w < 1000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("trig_width", 32'(w), 32'(TRIG_CYC));
    req = 2'b00;
    exp_q.push_back(exp_word(1'b0, 1'b0, 16'd100));
    wait_us(5);
    echo_pulse(100, lat);
    check("fall_to_result", 32'(lat), 32'd3);
    wait_idle(3000, "idle_single");

    // Timeout: requester 1, echo never rises
    @(posedge clk);
    #1 req = 2'b10;
    wait_trig(1'b1, 20, "to_trig_rise");
    check("gnt_timeout", 32'(gnt), 32'b10);
    req = 2'b00;
    exp_q.push_back(exp_word(1'b1, 1'b1, 16'd0));
    wait_trig(1'b0, 100, "to_trig_fall");
    check("echo_hold", 32'(echo_us), 32'd100);
    n = 0;
    while (result_valid !== 1'b1 && n < 2 * TIMEOUT_US * CLK_DIV_US) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'(TIMEOUT_US * CLK_DIV_US + 1));
    wait_idle(3000, "idle_timeout");

    // Round robin with both requests held; dropped after the third grant
    @(posedge clk);
    #1 req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_trig(1'b1, 4 * HOLDOFF_US * CLK_DIV_US, "rr_trig_rise");
      t_rise[k] = cyc;
      check("rr_gnt", 32'(gnt), (k % 2 == 1) ? 32'b10 : 32'b01);
      if (k == 2) req = 2'b00;
      exp_q.push_back(exp_word(k[0], 1'b0, 16'd300));
      wait_trig(1'b0, 100, "rr_trig_fall");
      wait_us(5);
      echo_pulse(300, lat);
      check("rr_fall_to_result", 32'(lat), 32'd3);
    end
    check("rr_spacing_01", 32'(t_rise[1] - t_rise[0] >= HOLDOFF_US * CLK_DIV_US), 32'd1);
    check("rr_spacing_12", 32'(t_rise[2] - t_rise[1] >= HOLDOFF_US * CLK_DIV_US), 32'd1);
    wait_idle(3000, "idle_rr");

    // Stale echo: high during trigger, falls 50 us into the rise wait
    @(posedge clk);
    #1 req = 2'b01;
    wait_trig(1'b1, 20, "stale_trig_rise");
    @(posedge clk);
    #1 uv_echo = 1'b1;
    req = 2'b00;
    wait_trig(1'b0, 100, "stale_trig_fall");
    exp_q.push_back(exp_word(1'b0, 1'b0, 16'd2000));
    wait_us(50);
    check("stale_ignored", 32'(dbg_state), 32'd2);
    @(posedge clk);
    #1 uv_echo = 1'b0;
    wait_us(10);
    echo_pulse(2000, lat);
    check("stale_fall_to_result", 32'(lat), 32'd3);
    wait_idle(3000, "idle_stale");

    // Reset during MEASURE: no result, async drop of outputs
    @(posedge clk);
    #1 req = 2'b01;
    wait_trig(1'b1, 20, "rst_trig_rise");
    req = 2'b00;
    wait_trig(1'b0, 100, "rst_trig_fall");
    wait_us(5);
    @(posedge clk);
    #1 uv_echo = 1'b1;
    wait_us(50);
    @(negedge clk);
    check("in_measure", 32'(dbg_state), 32'd3);
    nres = n_results;
    #2 rst = 1'b1;
    #1;
    check("async_rst", {29'd0, UV_trig, gnt}, 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    uv_echo = 1'b0;
    repeat (5) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_result_after_rst", 32'(n_results - nres), 32'd0);
    check("rst_clears_result", {16'd0, echo_us}, 32'd0);

    // New request after reset: pointer back at 0, only requester 1 asks
    exp_q.push_back(exp_word(1'b1, 1'b0, 16'd300));
    request_and_trig(2'b10, lat);
    check("post_rst_latency", 32'(lat), 32'd2);
    check("post_rst_gnt", 32'(gnt), 32'b10);
    req = 2'b00;
    wait_trig(1'b0, 100, "post_rst_trig_fall");
    wait_us(5);
    echo_pulse(300, lat);
    check("post_rst_fall_to_result", 32'(lat), 32'd3);
    wait_idle(3000, "idle_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ultrasonic_ping_scheduler.md
Name: ultrasonic_ping_scheduler

Overview:
- Owns the single HC-SR04-style ultrasonic sensor (UV_trig / UV_echo) used by the fault-detection path, and shares it between two requesters.
- Round-robin arbitration picks one requester, then sequences one ping: trigger pulse, echo rise wait, echo width measurement, timeout, holdoff.
- Returns echo width in µs and distance in mm, tagged with the owning requester.

Parameters:
- CLK_DIV_US, 50, clk_50M cycles per 1 µs tick.
- TRIG_US, 10, trigger pulse width in µs.
- TIMEOUT_US, 30000, maximum µs from trigger end to echo fall.
- HOLDOFF_US, 60000, minimum µs from result to next trigger.
- NEAR_MM, 100, fault threshold in mm (optional feature only).

Ports:
- clk_50M in 1: system clock, 50 MHz.
- reset in 1: asynchronous, active-high reset.
- req in 2: level request per requester, held until its grant/result.
- gnt out 2: one-hot owner of the current ping; 0 when idle.
- UV_trig out 1: sensor trigger.
- UV_echo in 1: sensor echo, asynchronous.
- busy out 1: high in any state except IDLE.
- result_valid out 1: one-cycle pulse when a result is ready.
- result_owner out 1: requester index for the result.
- timeout out 1: result came from a timeout (valid with result_valid).
- echo_us out 16: echo high time in µs.
- dist_mm out 14: distance in mm.
- fault_near out 1: distance below threshold (optional feature).

Behaviour:
- Reset: state IDLE; all outputs 0, including echo_us and dist_mm; RR pointer favours requester 0.
- UV_echo passes through a 2-FF synchroniser; all edge detection uses the synchronised copy.
- µs tick: prescaler counts 0..CLK_DIV_US-1; it resets on state entry and on echo rising edge.
- IDLE:
  - If any req bit is high, set gnt one-hot by round robin: the pointer requester wins ties, and the pointer moves past the winner.
  - Go to TRIG on the next cycle.
- TRIG:
  - UV_trig=1 for exactly TRIG_US×CLK_DIV_US cycles (500), then go to WAIT_RISE.
  - The timeout counter starts at 0 on WAIT_RISE entry.
- WAIT_RISE:
  - Needs the synchronised echo seen low, then a rising edge; a stale-high echo at entry is ignored until it falls.
  - On rise: clear echo_us, go to MEASURE.
- MEASURE:
  - echo_us increments once per µs tick while echo is high, saturating at 16'hFFFF.
  - On falling edge: compute dist_mm = (echo_us × 1412) >> 13 (27-bit product, truncated to 14 bits).
  - Pulse result_valid with timeout=0, then go to HOLDOFF.
- Timeout:
  - If the timeout counter reaches TIMEOUT_US in WAIT_RISE or MEASURE, pulse result_valid with timeout=1, echo_us=0, dist_mm=0.
  - Go to HOLDOFF.
- Result outputs (echo_us, dist_mm, timeout, result_owner) hold until the next result.
- gnt drops in the result_valid cycle.
- HOLDOFF: wait HOLDOFF_US ticks, then go to IDLE; requests made during holdoff are served afterwards.
- Fixed latency: request-to-UV_trig rise is 2 cycles; echo fall to result_valid is 3 cycles (2 sync + 1 register).
- A req bit dropped after grant does not abort the ping; the result is still delivered.
- Reset mid-ping: UV_trig drops asynchronously, state returns to IDLE, and no result_valid is produced.

Optional Feature:
- Macro: UV_FAULT_NEAR_EN.
- Defined: fault_near is registered, updated on each result_valid to (timeout==0 && dist_mm < NEAR_MM), and held otherwise.
- Not defined: fault_near is tied to 0 and no comparator is built.

Test Plan:
- Single ping: req=01, echo high 100 µs → gnt=01, UV_trig high 500 cycles, result_valid with echo_us=100, dist_mm=17, timeout=0, owner=0.
- Round robin: req=11 held, echo 300 µs each time → owners alternate 0,1,0, each result echo_us=300, dist_mm=51, holdoff ≥60000 µs between trigger rises.
- Timeout: req=10, echo never rises → result_valid at 30000 µs after trigger end, timeout=1, echo_us=0, owner=1.
- Stale echo: echo already high at TRIG, falls 50 µs into WAIT_RISE, then pulses 2000 µs → echo_us=2000, dist_mm=344.
- Reset during MEASURE: assert reset → UV_trig, gnt, busy = 0 immediately, no result_valid; a new req afterwards completes normally.
- With UV_FAULT_NEAR_EN: echo 100 µs → fault_near=1; then echo 2000 µs → fault_near=0; without the macro fault_near stays 0.
